// File: rtl/uart_tx_communication.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_communication
// Description : Board-to-board UART transmitter. Game bytes are queued in a
//               small circular FIFO and sent as 8N1 frames, LSB first, on a
//               registered, idle-high serial line.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_communication #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    localparam int c_DEPTH = 2 ** ADDR_W;
    // A 1-cycle bit still needs a 1-bit counter so the compare stays legal.
    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // FIFO
    logic [7:0]        r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_full;
    logic              r_empty;
    logic              w_push;
    logic              w_pop;

    // Serialiser
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_tx;
    logic               w_tx_line;
    logic               w_done_tick;

    // Full is judged on the registered flag, so a write while full is dropped
    // even if the serialiser pops in the same cycle.
    assign w_push = tx_wr & ~r_full;

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            // Push and pop together leave occupancy, and so both flags, unchanged.
            if (w_push && !w_pop) begin
                r_empty <= 1'b0;
                r_full  <= ((r_wr_ptr + ADDR_W'(1)) == r_rd_ptr);
            end else if (w_pop && !w_push) begin
                r_full  <= 1'b0;
                r_empty <= ((r_rd_ptr + ADDR_W'(1)) == r_wr_ptr);
            end
        end
    end

    // Serialiser state, bit timer, bit index, shift register and line register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_line;
        end
    end

    // Next-state logic, FIFO pop and the line level for the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_done_tick = 1'b0;
        w_tx_line   = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                w_tx_line = 1'b1;
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                w_tx_line = 1'b0;
                if (r_cnt == c_CNT_MAX) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = c_ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_DATA: begin
                w_tx_line = r_shift[0];
                if (r_cnt == c_CNT_MAX) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_STOP: begin
                w_tx_line = 1'b1;
                if (r_cnt == c_CNT_MAX) begin
                    w_cnt_nxt   = '0;
                    w_done_tick = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign tx           = r_tx;
    assign tx_full      = r_full;
    assign tx_busy      = (r_state != c_ST_IDLE) | ~r_empty;
    assign tx_done_tick = w_done_tick;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_communication.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_communication
// Description : Self-checking bench for uart_tx_communication. A frame-level
//               model (byte queue + frame start times) predicts the line,
//               busy, full and done outputs every cycle; directed tests add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_communication;

    localparam int c_CPB   = 4;
    localparam int c_FRAME = 10 * c_CPB;
    localparam int c_CAP   = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_full, tx, tx_busy, tx_done_tick;
    logic [7:0] tx_data1 = 8'h00;
    logic       tx_wr1 = 1'b0;
    logic       tx_full1, tx1, tx_busy1, tx_done_tick1;

    always #5 clk = ~clk;

    uart_tx_communication #(.CLKS_PER_BIT(c_CPB), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_full(tx_full), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
    );

    uart_tx_communication #(.CLKS_PER_BIT(1), .ADDR_W(2)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_wr(tx_wr1),
        .tx_full(tx_full1), .tx(tx1), .tx_busy(tx_busy1), .tx_done_tick(tx_done_tick1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Per-cycle capture of both DUTs, indexed by clock edge number.
    logic cap_tx [c_CAP];
    logic cap_busy [c_CAP];
    logic cap_full [c_CAP];
    logic cap_tick [c_CAP];
    logic cap_tx1 [c_CAP];
    logic cap_busy1 [c_CAP];
    logic cap_tick1 [c_CAP];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Inputs as the DUT saw them at each rising edge.
    logic       s_rst, s_wr;
    logic [7:0] s_data;
    always @(posedge clk) begin
        s_rst  <= rst;
        s_wr   <= tx_wr;
        s_data <= tx_data;
    end

    // Frame-level model: each accepted byte gets a line start time of
    // max(accept edge + 2, previous start + 10*C + 1); its byte leaves the FIFO
    // one edge before its start. Outputs follow from those times.
    logic [7:0] m_byte [$];
    int         m_start [$];
    int         m_occ;
    logic       m_full;

    initial begin
        int   d, st;
        logic e_tx, e_busy, e_tick;
        m_occ  = 0;
        m_full = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (s_rst) begin
                m_byte.delete();
                m_start.delete();
                m_occ = 0;
            end else begin
                foreach (m_start[i]) begin
                    if (m_start[i] - 1 == cyc) m_occ--;
                end
                if (s_wr && !m_full) begin
                    st = cyc + 2;
                    if (m_start.size() > 0 && m_start[$] + c_FRAME + 1 > st)
                        st = m_start[$] + c_FRAME + 1;
                    m_byte.push_back(s_data);
                    m_start.push_back(st);
                    m_occ++;
                end
            end
            m_full = (m_occ == 4);

            e_tx   = 1'b1;
            e_busy = (m_occ > 0);
            e_tick = 1'b0;
            foreach (m_start[i]) begin
                d = cyc - m_start[i];
                if (d >= -1 && d <= c_FRAME - 2) e_busy = 1'b1;
                if (d == c_FRAME - 2) e_tick = 1'b1;
                if (d >= 0 && d < c_FRAME) begin
                    if (d / c_CPB == 0) e_tx = 1'b0;
                    else if (d / c_CPB <= 8) e_tx = m_byte[i][d / c_CPB - 1];
                end
            end

            check_bit("model_tx", tx, e_tx);
            check_bit("model_busy", tx_busy, e_busy);
            check_bit("model_full", tx_full, m_full);
            check_bit("model_done_tick", tx_done_tick, e_tick);

            if (cyc < c_CAP) begin
                cap_tx[cyc]    = tx;
                cap_busy[cyc]  = tx_busy;
                cap_full[cyc]  = tx_full;
                cap_tick[cyc]  = tx_done_tick;
                cap_tx1[cyc]   = tx1;
                cap_busy1[cyc] = tx_busy1;
                cap_tick1[cyc] = tx_done_tick1;
            end
        end
    end

    // Directed stimulus with literal expectations.
    initial begin
        int         k, t0, n;
        logic [9:0] fr;

        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check_bit("reset_tx", tx, 1'b1);
        check_bit("reset_busy", tx_busy, 1'b0);
        check_bit("reset_full", tx_full, 1'b0);
        check_bit("reset_tick", tx_done_tick, 1'b0);
        check_bit("reset_tx_c1", tx1, 1'b1);
        check_bit("reset_busy_c1", tx_busy1, 1'b0);
        step();
        step();

        // 1: single 0xA5; data input changed right after acceptance
        k = cyc + 2;
        tx_data = 8'hA5; tx_wr = 1'b1;
        step();
        tx_wr = 1'b0; tx_data = 8'h3C;
        repeat (50) step();
        t0 = k + 2;
        fr = {1'b1, 8'hA5, 1'b0};
        check_bit("t1_high_before_start", cap_tx[t0 - 1], 1'b1);
        for (int j = 0; j < 10; j++) check_bit("t1_bit", cap_tx[t0 + 4 * j + 2], fr[j]);
        n = 0;
        for (int i = k; i < k + 50; i++) if (cap_tick[i]) n++;
        check_int("t1_tick_count", n, 1);
        check_bit("t1_tick_pos", cap_tick[t0 + 38], 1'b1);
        check_bit("t1_busy_last", cap_busy[t0 + 38], 1'b1);
        check_bit("t1_busy_low", cap_busy[t0 + 39], 1'b0);

        // 2: leader frame in flight, then 0x01..0x04 fill the FIFO
        k = cyc + 2;
        tx_data = 8'hC3; tx_wr = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) begin
            tx_data = 8'(i);
            step();
        end
        tx_wr = 1'b0;
        repeat (215) step();
        check_bit("t2_not_full_3rd", cap_full[k + 3], 1'b0);
        check_bit("t2_full_4th", cap_full[k + 4], 1'b1);
        for (int f = 0; f < 5; f++) begin
            check_bit("t2_pre_start_high", cap_tx[k + 1 + 41 * f], 1'b1);
            check_bit("t2_start_low", cap_tx[k + 2 + 41 * f], 1'b0);
        end

        // 3: leader, then 0x11..0x15; the fifth is written while full
        k = cyc + 2;
        tx_data = 8'hE7; tx_wr = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            tx_data = 8'h11 + 8'(i);
            step();
        end
        tx_wr = 1'b0;
        repeat (230) step();
        check_bit("t3_full_at_5th", cap_full[k + 4], 1'b1);
        check_bit("t3_full_after_drop", cap_full[k + 5], 1'b1);
        n = 0;
        for (int i = k; i < k + 230; i++) if (cap_tick[i]) n++;
        check_int("t3_tick_count", n, 5);
        check_bit("t3_no_sixth_start", cap_tx[k + 2 + 41 * 5], 1'b1);

        // 4: reset during data bit 3 of 0x5A with two bytes queued
        k = cyc + 2;
        tx_data = 8'h5A; tx_wr = 1'b1;
        step();
        tx_data = 8'h01;
        step();
        tx_data = 8'h02;
        step();
        tx_wr = 1'b0;
        repeat (16) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (70) step();
        check_bit("t4_bit2_low", cap_tx[k + 17], 1'b0);
        check_bit("t4_bit3_high", cap_tx[k + 18], 1'b1);
        check_bit("t4_tx_after_rst", cap_tx[k + 19], 1'b1);
        check_bit("t4_busy_after_rst", cap_busy[k + 19], 1'b0);
        check_bit("t4_full_after_rst", cap_full[k + 19], 1'b0);
        n = 0;
        for (int i = k + 19; i < k + 88; i++) if (cap_tick[i] || !cap_tx[i]) n++;
        check_int("t4_quiet_after_rst", n, 0);

        // 5: three queued behind a frame, write lands on the pop edge
        k = cyc + 2;
        for (int i = 0; i < 4; i++) begin
            tx_data = 8'h21 + 8'(i); tx_wr = 1'b1;
            step();
        end
        tx_wr = 1'b0;
        repeat (38) step();
        tx_data = 8'h77; tx_wr = 1'b1;
        step();
        tx_wr = 1'b0;
        repeat (175) step();
        check_bit("t5_not_full_before", cap_full[k + 41], 1'b0);
        check_bit("t5_not_full_after", cap_full[k + 42], 1'b0);
        t0 = k + 2 + 41 * 4;
        fr = {1'b1, 8'h77, 1'b0};
        for (int j = 0; j < 10; j++) check_bit("t5_last_frame_bit", cap_tx[t0 + 4 * j + 2], fr[j]);
        check_bit("t5_idle_after", cap_tx[t0 + 41], 1'b1);

        // 6: one clock per bit, 0xFF then 0x00
        k = cyc + 2;
        tx_data1 = 8'hFF; tx_wr1 = 1'b1;
        step();
        tx_data1 = 8'h00;
        step();
        tx_wr1 = 1'b0;
        repeat (30) step();
        for (int i = 0; i < 23; i++) begin
            check_bit("t6_tx", cap_tx1[k + 2 + i], (i == 0 || (i >= 11 && i <= 19)) ? 1'b0 : 1'b1);
            check_bit("t6_tick", cap_tick1[k + 2 + i], (i == 8 || i == 19) ? 1'b1 : 1'b0);
            check_bit("t6_busy", cap_busy1[k + 2 + i], (i < 20) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
